// File: rtl/cdc_channel_arbiter.sv
// Round-robin arbiter sharing one single-word handshake CDC write channel between NUM_REQ requesters.
// Optional watchdog abort on a stalled SEND is compiled in with CDC_ARB_TIMEOUT_EN.
module cdc_channel_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BITWIDTH = 8,
  parameter int TIMEOUT  = 255,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                        wr_clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BITWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [IDW+BITWIDTH-1:0]     out_data,
  input  logic                        out_ready,
  output logic                        busy,
  output logic [15:0]                 xfer_count,
  output logic                        timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_chk_num_req
    $error("cdc_channel_arbiter: NUM_REQ out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_timeout
    $error("cdc_channel_arbiter: TIMEOUT out of range");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [IDW-1:0]            r_rr_ptr;
  logic [IDW+BITWIDTH-1:0]   r_out_data;
  logic [15:0]               r_xfer_count;

  logic                      w_found;
  logic [IDW-1:0]            w_win;
  logic [IDW-1:0]            w_idx;
  logic                      w_capture;
  logic                      w_done;
  logic                      w_abort;
  logic [IDW-1:0]            w_id;
  logic [IDW-1:0]            w_ptr_next;
  logic [NUM_REQ-1:0]        w_req_ready;

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((r_rr_ptr + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  logic [15:0] r_wait;
  logic        r_timeout_err;
`endif

  always_ff @(posedge wr_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_capture = 1'b1;
          w_next    = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          w_done = 1'b1;
          w_next = GAP;
        end
`ifdef CDC_ARB_TIMEOUT_EN
        else if (r_wait == 16'(TIMEOUT - 1)) begin
          w_abort = 1'b1;
          w_next  = GAP;
        end
`endif
      end
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The captured word's tag doubles as the winner index for the pointer advance.
  assign w_id       = r_out_data[IDW+BITWIDTH-1 -: IDW];
  assign w_ptr_next = (w_id == IDW'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_out_data   <= '0;
      r_xfer_count <= '0;
    end else begin
      if (w_capture)
        r_out_data <= {w_win, req_data[w_win*BITWIDTH +: BITWIDTH]};
      if (w_done) begin
        r_rr_ptr     <= w_ptr_next;
        r_xfer_count <= r_xfer_count + 16'd1;
      end else if (w_abort) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_wait        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_capture)
        r_wait <= '0;
      else if (r_state == SEND && !out_ready)
        r_wait <= r_wait + 16'd1;
      if (w_abort)
        r_timeout_err <= 1'b1;
    end
  end
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  // Reset-cycle requests are never acknowledged.
  always_comb begin
    w_req_ready = '0;
    if (w_capture && !rst)
      w_req_ready[w_win] = 1'b1;
  end

  assign req_ready  = w_req_ready;
  assign out_valid  = (r_state == SEND);
  assign out_data   = r_out_data;
  assign busy       = (r_state != IDLE);
  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Directed self-checking bench for cdc_channel_arbiter (NUM_REQ=4, BITWIDTH=8, TIMEOUT=5).
module tb_cdc_channel_arbiter;

  logic        wr_clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [9:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic [15:0] xfer_count;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 wr_clk = ~wr_clk;

  cdc_channel_arbiter #(
    .NUM_REQ (4),
    .BITWIDTH(8),
    .TIMEOUT (5)
  ) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .xfer_count (xfer_count),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    int unsigned ids [5];
    ids = '{0, 1, 2, 3, 0};

    // Reset with requests pending: they must be ignored.
    rst = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211; out_ready = 1'b1;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_xfer",      32'(xfer_count), 32'h0);
    chk("rst_timeout",   32'(timeout_err), 32'h0);

    // Single request from requester 1.
    rst = 1'b0; req_valid = 4'b0010; req_data = 32'h0000A500;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_out_valid", 32'(out_valid), 32'h1);
    chk("single_out_data",  32'(out_data),  32'h1A5);
    chk("single_busy",      32'(busy),      32'h1);
    chk("single_send_rdy",  32'(req_ready), 32'h0);
    tick();
    chk("single_gap_valid", 32'(out_valid), 32'h0);
    chk("single_gap_busy",  32'(busy),      32'h1);
    chk("single_xfer",      32'(xfer_count), 32'h1);
    tick();
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Fairness from rr_ptr=0 with everyone requesting.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1111; req_data = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fair_req_ready", 32'(req_ready), 32'h1 << ids[i]);
      tick();
      chk("fair_out_data", 32'(out_data), (ids[i] << 8) | (32'h11 * (ids[i] + 1)));
      chk("fair_send_rdy", 32'(req_ready), 32'h0);
      tick();
      chk("fair_gap_rdy", 32'(req_ready), 32'h0);
      tick();
    end
    req_valid = 4'b0000;
    chk("fair_xfer", 32'(xfer_count), 32'd5);

    // Backpressure: requester 2 word held for 20 stalled cycles (rr_ptr=1).
    req_valid = 4'b0100; req_data = 32'h003C0000; out_ready = 1'b0;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_data",  32'(out_data),  32'h23C);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_last_valid", 32'(out_valid), 32'h1);
    tick();
    chk("bp_gap_valid", 32'(out_valid), 32'h0);
    chk("bp_xfer",      32'(xfer_count), 32'd6);
    tick();

    // Wrap: rr_ptr=3 with requesters 3 and 0 pending.
    req_valid = 4'b1001; req_data = 32'hD3000011;
    #1;
    chk("wrap_req3", 32'(req_ready), 32'h8);
    tick();
    chk("wrap_data3", 32'(out_data), 32'h3D3);
    tick(); tick();
    chk("wrap_req0", 32'(req_ready), 32'h1);
    tick();
    chk("wrap_data0", 32'(out_data), 32'h011);
    tick(); tick();
    req_valid = 4'b0000;
    chk("wrap_xfer", 32'(xfer_count), 32'd8);

    // Reset while in SEND (rr_ptr=1, requester 2 wins).
    req_valid = 4'b0100; req_data = 32'h00770000; out_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    chk("rsend_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    chk("rsend_out_valid", 32'(out_valid), 32'h0);
    chk("rsend_busy",      32'(busy),      32'h0);
    chk("rsend_data",      32'(out_data),  32'h0);
    chk("rsend_xfer",      32'(xfer_count), 32'h0);
    // With 0 and 2 pending, granting 0 proves rr_ptr returned to 0.
    rst = 1'b0; req_valid = 4'b0101; req_data = 32'h00990055; out_ready = 1'b1;
    #1;
    chk("rsend_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("rsend_data0", 32'(out_data), 32'h055);
    tick(); tick();
    chk("rsend_xfer1", 32'(xfer_count), 32'h1);

`ifdef CDC_ARB_TIMEOUT_EN
    // Watchdog: requester 1 stalls (rr_ptr=1), aborted after 5 SEND cycles.
    req_valid = 4'b0010; req_data = 32'h0000BB00; out_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("to_valid", 32'(out_valid), 32'h1);
      tick();
    end
    chk("to_dropped", 32'(out_valid), 32'h0);
    chk("to_err",     32'(timeout_err), 32'h1);
    chk("to_xfer",    32'(xfer_count), 32'h1);
    tick();
    req_valid = 4'b0110; out_ready = 1'b1;
    #1;
    chk("to_next_grant", 32'(req_ready), 32'h4);
    chk("to_err_sticky", 32'(timeout_err), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick(); tick();
`else
    chk("no_to_err", 32'(timeout_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
